// File: rtl/demorgan_pkg.sv
// ============================================================================
// demorgan_pkg : shared states, width limit and vector-count helper
// Rev 1.0
// ============================================================================
`default_nettype none

package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEMORGAN_MAX_WIDTH = 4;

  // Number of {a,b} combinations swept for a given operand width.
  function automatic int unsigned vec_count(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/demorgan_type_1_rhs.sv
// ============================================================================
// demorgan_type_1_rhs : AND-of-inverted-inputs form, o_c = (~a) & (~b)
// Rev 1.0
// ============================================================================
`default_nettype none

module demorgan_type_1_rhs #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_c
);

  assign o_c = (~i_a) & (~i_b);

endmodule

`default_nettype wire

// File: rtl/two_input_demorgan_type_1_checker.sv
// ============================================================================
// two_input_demorgan_type_1_checker : exhaustive sweep comparing ~(a|b) to
// (~a)&(~b); optional DEMORGAN_FAULT_INJECT_EN adds an inject port.  Rev 1.0
// ============================================================================
`default_nettype none

module two_input_demorgan_type_1_checker
  import demorgan_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef DEMORGAN_FAULT_INJECT_EN
  input  logic                 inject,
`endif
  output logic                 vec_valid,
  output logic [WIDTH-1:0]     vec_a,
  output logic [WIDTH-1:0]     vec_b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     mismatch_count,
  output logic [2*WIDTH-1:0]   first_fail_idx
);

  localparam int IDXW = 2 * WIDTH;
  localparam int CNTW = 2 * WIDTH + 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(vec_count(WIDTH) - 1);

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_vec_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_cmp_valid;
  logic [WIDTH-1:0]  r_cmp_lhs;
  logic [WIDTH-1:0]  r_cmp_rhs;
  logic [IDXW-1:0]   r_cmp_idx;
  logic [CNTW-1:0]   r_cnt;
  logic [IDXW-1:0]   r_first;
`ifdef DEMORGAN_FAULT_INJECT_EN
  logic              r_inject;
`endif

  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_lhs;
  logic [WIDTH-1:0]  w_rhs_true;
  logic [WIDTH-1:0]  w_rhs;
  logic              w_cmp_mismatch;
  logic [CNTW-1:0]   w_cnt_next;

  assign w_a   = r_idx[IDXW-1:WIDTH];
  assign w_b   = r_idx[WIDTH-1:0];
  assign w_lhs = ~(w_a | w_b);

  demorgan_type_1_rhs #(
    .WIDTH (WIDTH)
  ) u_rhs (
    .i_a (w_a),
    .i_b (w_b),
    .o_c (w_rhs_true)
  );

  always_comb begin
    w_rhs = w_rhs_true;
`ifdef DEMORGAN_FAULT_INJECT_EN
    if (r_inject) begin
      w_rhs[0] = 1'b1;
    end
`endif
  end

  assign w_cmp_mismatch = r_cmp_valid && (r_cmp_lhs != r_cmp_rhs);
  assign w_cnt_next     = (w_cmp_mismatch && (r_cnt != {CNTW{1'b1}}))
                          ? r_cnt + CNTW'(1) : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_lhs   <= '0;
      r_cmp_rhs   <= '0;
      r_cmp_idx   <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
`ifdef DEMORGAN_FAULT_INJECT_EN
      r_inject    <= 1'b0;
`endif
    end else begin
      // Compare stage trails the presented vector by one cycle.
      r_cmp_valid <= (r_state == SWEEP);
      r_cmp_lhs   <= w_lhs;
      r_cmp_rhs   <= w_rhs;
      r_cmp_idx   <= r_idx;
      r_cnt       <= w_cnt_next;
      if (w_cmp_mismatch && (r_cnt == '0)) begin
        r_first <= r_cmp_idx;
      end

      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cnt       <= '0;
            r_first     <= '0;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_vec_valid <= 1'b1;
`ifdef DEMORGAN_FAULT_INJECT_EN
            r_inject    <= inject;
`endif
            r_state     <= SWEEP;
          end
        end
        SWEEP: begin
          r_idx <= r_idx + IDXW'(1);
          if (r_idx == c_LAST_IDX) begin
            r_vec_valid <= 1'b0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_cnt_next == '0);
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec_valid      = r_vec_valid;
  assign vec_a          = w_a;
  assign vec_b          = w_b;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign mismatch_count = r_cnt;
  assign first_fail_idx = r_first;

endmodule

`default_nettype wire

// File: tb/tb_two_input_demorgan_type_1_checker.sv
// ============================================================================
// tb_two_input_demorgan_type_1_checker : table, random and corner-case sweeps
// on WIDTH=1 and WIDTH=2 instances against an arithmetic reference model.
// ============================================================================
`default_nettype none

module tb_two_input_demorgan_type_1_checker;

  logic clk = 1'b0;
  logic rst;
  logic start1;
  logic start2;
`ifdef DEMORGAN_FAULT_INJECT_EN
  logic inject;
`endif

  always #5 clk = ~clk;

  logic       d1_vv, d1_busy, d1_done, d1_pass;
  logic [0:0] d1_a, d1_b;
  logic [2:0] d1_cnt;
  logic [1:0] d1_ffi;

  logic       d2_vv, d2_busy, d2_done, d2_pass;
  logic [1:0] d2_a, d2_b;
  logic [4:0] d2_cnt;
  logic [3:0] d2_ffi;

  two_input_demorgan_type_1_checker #(.WIDTH(1)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .start          (start1),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .inject         (inject),
`endif
    .vec_valid      (d1_vv),
    .vec_a          (d1_a),
    .vec_b          (d1_b),
    .busy           (d1_busy),
    .done           (d1_done),
    .pass           (d1_pass),
    .mismatch_count (d1_cnt),
    .first_fail_idx (d1_ffi)
  );

  two_input_demorgan_type_1_checker #(.WIDTH(2)) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .start          (start2),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .inject         (inject),
`endif
    .vec_valid      (d2_vv),
    .vec_a          (d2_a),
    .vec_b          (d2_b),
    .busy           (d2_busy),
    .done           (d2_done),
    .pass           (d2_pass),
    .mismatch_count (d2_cnt),
    .first_fail_idx (d2_ffi)
  );

  int sel;
  logic       o_vv, o_busy, o_done, o_pass;
  logic [3:0] o_idx;
  logic [4:0] o_cnt;
  logic [3:0] o_ffi;

  always_comb begin
    o_vv = d1_vv; o_busy = d1_busy; o_done = d1_done; o_pass = d1_pass;
    o_idx = {2'b00, d1_a, d1_b}; o_cnt = {2'b00, d1_cnt}; o_ffi = {2'b00, d1_ffi};
    if (sel == 2) begin
      o_vv = d2_vv; o_busy = d2_busy; o_done = d2_done; o_pass = d2_pass;
      o_idx = {d2_a, d2_b}; o_cnt = d2_cnt; o_ffi = d2_ffi;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 2) start2 = v;
    else        start1 = v;
  endtask

  // Reference: enumerate every {a,b}, complement via (mask - x).
  task automatic model(input int w, input bit inj, output int cnt, output int first);
    int mask;
    int a, b, lhs, rhs;
    mask  = (1 << w) - 1;
    cnt   = 0;
    first = 0;
    for (int idx = 0; idx < (1 << (2 * w)); idx++) begin
      a   = idx / (1 << w);
      b   = idx % (1 << w);
      lhs = mask - (a | b);
      rhs = (mask - a) & (mask - b);
      if (inj) rhs = rhs | 1;
      if (lhs != rhs) begin
        if (cnt == 0) first = idx;
        cnt++;
      end
    end
  endtask

  // One sweep from a start pulse, checked period by period after the start edge.
  task automatic run_sweep(input int w, input bit inj, input bit noise,
                           input int ecnt, input int efirst, input bit epass,
                           input string tag);
    int n;
    n   = 1 << (2 * w);
    sel = w;
    @(negedge clk);
    set_start(w, 1'b1);
`ifdef DEMORGAN_FAULT_INJECT_EN
    inject = inj;
`else
    if (inj) begin
      checks++; errors++;
      $display("FAIL %s.inject: got 0, expected 1 (port absent)", tag);
    end
`endif
    @(posedge clk);
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        set_start(w, 1'b0);
`ifdef DEMORGAN_FAULT_INJECT_EN
        inject = 1'b0;
`endif
      end else if (noise && k <= n + 2) begin
        set_start(w, logic'($urandom_range(0, 1)));
      end else begin
        set_start(w, 1'b0);
      end
      if (k <= n) begin
        chk({tag, ".vec_valid"}, o_vv, 1);
        chk({tag, ".busy"}, o_busy, 1);
        chk({tag, ".vec_idx"}, o_idx, k - 1);
        chk({tag, ".done_early"}, o_done, 0);
      end else if (k == n + 1) begin
        chk({tag, ".drain_valid"}, o_vv, 0);
        chk({tag, ".drain_busy"}, o_busy, 1);
        chk({tag, ".drain_done"}, o_done, 0);
      end else if (k == n + 2) begin
        chk({tag, ".done"}, o_done, 1);
        chk({tag, ".done_busy"}, o_busy, 0);
        chk({tag, ".count"}, o_cnt, ecnt);
        chk({tag, ".first_fail"}, o_ffi, efirst);
        chk({tag, ".pass"}, o_pass, epass);
      end else begin
        chk({tag, ".idle_done"}, o_done, 0);
        chk({tag, ".idle_busy"}, o_busy, 0);
        chk({tag, ".pass_hold"}, o_pass, epass);
      end
    end
  endtask

  typedef struct {
    int    w;
    bit    inj;
    bit    noise;
    int    exp_cnt;
    int    exp_first;
    bit    exp_pass;
    string name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1;
`ifdef DEMORGAN_FAULT_INJECT_EN
    inject = 1'b0;
`endif
    tbl.push_back('{1, 1'b0, 1'b0, 0, 0, 1'b1, "w1_basic"});
    tbl.push_back('{2, 1'b0, 1'b0, 0, 0, 1'b1, "w2_basic"});
    tbl.push_back('{1, 1'b0, 1'b1, 0, 0, 1'b1, "w1_midstart"});
`ifdef DEMORGAN_FAULT_INJECT_EN
    tbl.push_back('{1, 1'b1, 1'b0, 3, 1, 1'b0, "w1_inject"});
    tbl.push_back('{1, 1'b0, 1'b0, 0, 0, 1'b1, "w1_after_inject"});
    tbl.push_back('{2, 1'b1, 1'b0, 12, 1, 1'b0, "w2_inject"});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.w1", {d1_vv, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_cnt, d1_ffi}, 0);
    chk("rst.w2", {d2_vv, d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_cnt, d2_ffi}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.w1_busy", d1_busy, 0);

    foreach (tbl[i]) begin
      run_sweep(tbl[i].w, tbl[i].inj, tbl[i].noise, tbl[i].exp_cnt,
                tbl[i].exp_first, tbl[i].exp_pass, tbl[i].name);
    end

    // Reset in the middle of a WIDTH=1 sweep.
    sel = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.pre_busy", d1_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort.async_zero", {d1_vv, d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_cnt, d1_ffi}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort.no_done", d1_done, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort.stay_idle", d1_done | d1_busy, 0);
    end
    run_sweep(1, 1'b0, 1'b0, 0, 0, 1'b1, "after_abort");

    // Start held high: back-to-back sweeps with one idle cycle between them.
    sel = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 14) start1 = 1'b0;
      chk($sformatf("hold.done_p%0d", k), d1_done, (k == 6 || k == 13));
      chk($sformatf("hold.busy_p%0d", k), d1_busy,
          ((k >= 1 && k <= 5) || (k >= 8 && k <= 12)));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold.stopped", d1_busy | d1_done, 0);
    end

    // Randomized sweeps against the reference model.
    for (int r = 0; r < 8; r++) begin
      int  w, ecnt, efirst, gap;
      bit  inj, noise;
      w     = int'($urandom_range(1, 2));
`ifdef DEMORGAN_FAULT_INJECT_EN
      inj   = bit'($urandom_range(0, 1));
`else
      inj   = 1'b0;
`endif
      noise = bit'($urandom_range(0, 1));
      gap   = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      model(w, inj, ecnt, efirst);
      run_sweep(w, inj, noise, ecnt, efirst, (ecnt == 0), $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
